// File: rtl/fetch_unit_if.sv
// Instruction-fetch stage: owns the PC, drives a synchronous instruction ROM
// and registers the returned word into the IF/ID pipeline register.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               freeze PC, pending request and IF/ID register
//   redirect/_pc        flush and restart fetch at redirect_pc (beats stall)
//   imem_en/_addr       ROM read enable and address (address = PC)
//   imem_data           ROM word for the previous enabled cycle's address
//   instr/opcode/pc/valid_IF_ID   IF/ID register contents for the decoder
//   done                program exhausted and nothing in flight
module fetch_unit_if #(
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PROG_LEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr_IF_ID,
  output logic [3:0]         opcode_IF_ID,
  output logic [ADDR_W-1:0]  pc_IF_ID,
  output logic               valid_IF_ID,
  output logic               done
);

  // One extra PC bit so PC can sit at PROG_LEN == 2^ADDR_W.
  localparam int unsigned PC_W = ADDR_W + 1;
  localparam logic [PC_W-1:0] END_PC = PC_W'(PROG_LEN);
  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);
  localparam bit FULL_SPACE = (PROG_LEN == (32'd1 << ADDR_W));
  localparam logic [INSTR_W-1:0] NOP = {4'b0101, {(INSTR_W-4){1'b0}}};

  logic [PC_W-1:0]    pc_q, pc_d, pc_inc;
  logic               req_valid_q, req_valid_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic               valid_q, valid_d;
  logic               at_end;

  assign at_end       = (pc_q == END_PC);
  assign imem_addr    = pc_q[ADDR_W-1:0];
  assign imem_en      = !stall && !redirect && !at_end;
  assign done         = at_end && !req_valid_q;
  assign instr_IF_ID  = instr_q;
  assign opcode_IF_ID = instr_q[INSTR_W-1 -: 4];
  assign pc_IF_ID     = pc_out_q;
  assign valid_IF_ID  = valid_q;

  // PC increment wraps modulo 2^ADDR_W, except that a full address space
  // must be able to reach PROG_LEN itself to stop fetching.
  always_comb begin
    pc_inc = pc_q + PC_W'(1);
    if (!FULL_SPACE && (&pc_q[ADDR_W-1:0])) begin
      pc_inc = '0;
    end
  end

  // Next-state: redirect beats stall; normal flow advances the 2-stage pipe.
  always_comb begin
    pc_d        = pc_q;
    req_valid_d = req_valid_q;
    req_pc_d    = req_pc_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    valid_d     = valid_q;
    if (redirect) begin
      pc_d        = {1'b0, redirect_pc};
      req_valid_d = 1'b0;
      instr_d     = NOP;
      valid_d     = 1'b0;
    end else if (!stall) begin
      instr_d  = req_valid_q ? imem_data : NOP;
      pc_out_d = req_pc_q;
      valid_d  = req_valid_q;
      if (!at_end) begin
        req_valid_d = 1'b1;
        req_pc_d    = pc_q[ADDR_W-1:0];
        pc_d        = pc_inc;
      end else begin
        req_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RST_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
      instr_q     <= NOP;
      pc_out_q    <= '0;
      valid_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit_if.sv
// Self-checking bench for fetch_unit_if with a 6-word program, a synchronous
// ROM model, and a cycle-level reference that looks instructions up directly
// in the program array by PC.
module tb_fetch_unit_if;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned RESET_PC = 0;
  localparam int unsigned PROG_LEN = 6;
  localparam logic [15:0] NOP = 16'h5000;

  logic        clk;
  logic        rst, stall, redirect;
  logic [7:0]  redirect_pc;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [15:0] rom_q;
  logic [15:0] instr_IF_ID;
  logic [3:0]  opcode_IF_ID;
  logic [7:0]  pc_IF_ID;
  logic        valid_IF_ID;
  logic        done;

  logic [15:0] mem [256];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: next PC, last fetch issued, and expected IF/ID contents.
  int unsigned m_pc = 0, m_fpc = 0, m_opc = 0;
  bit          m_fv = 0, m_ov = 0;
  logic [15:0] m_oinstr = NOP;

  logic [38:0] obs;
  assign obs = {instr_IF_ID, opcode_IF_ID, pc_IF_ID, valid_IF_ID, imem_en, imem_addr, done};

  fetch_unit_if #(
    .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .PROG_LEN(PROG_LEN)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_data(rom_q), .instr_IF_ID(instr_IF_ID), .opcode_IF_ID(opcode_IF_ID),
    .pc_IF_ID(pc_IF_ID), .valid_IF_ID(valid_IF_ID), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM that holds its output when not enabled.
  always_ff @(posedge clk) begin
    if (imem_en) rom_q <= mem[imem_addr];
  end

  function automatic logic [38:0] exp_vec();
    logic en, dn;
    en = !stall && !redirect && (m_pc != PROG_LEN);
    dn = (m_pc == PROG_LEN) && !m_fv;
    return {m_oinstr, m_oinstr[15:12], 8'(m_opc), m_ov, en, 8'(m_pc), dn};
  endfunction

  task automatic model_update();
    if (rst) begin
      m_pc = RESET_PC; m_fv = 0; m_fpc = 0; m_oinstr = NOP; m_opc = 0; m_ov = 0;
    end else if (redirect) begin
      m_pc = 32'(redirect_pc); m_fv = 0; m_oinstr = NOP; m_ov = 0;
    end else if (!stall) begin
      m_oinstr = m_fv ? mem[m_fpc] : NOP;
      m_opc    = m_fpc;
      m_ov     = m_fv;
      if (m_pc != PROG_LEN) begin
        m_fv = 1; m_fpc = m_pc; m_pc = (m_pc + 1) % 256;
      end else begin
        m_fv = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic load_program();
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 5; i++) mem[i] = {4'(i), 12'($urandom)};
    mem[5] = NOP;
  endtask

  task automatic do_reset();
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    logic [38:0] e;
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    tick(); tick();
    rst = 0; #1;
    e = exp_vec();
    n_tests++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_model: got %h exp %h", obs, e); end
    n_tests++;
    if (obs !== {NOP, 4'b0101, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL reset_values: got %h exp %h", obs, {NOP, 4'b0101, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0});
    end
  endtask

  task automatic test_program();
    logic [38:0] e;
    rst = 1; stall = 0; redirect = 0;
    load_program();
    tick();
    rst = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      e = exp_vec();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL program_model c%0d: got %h exp %h", c, obs, e); end
      if (c >= 2 && c <= 7) begin
        n_tests++;
        if ({valid_IF_ID, opcode_IF_ID, pc_IF_ID} !== {1'b1, 4'(c - 2), 8'(c - 2)}) begin
          n_fail++; $display("FAIL program_seq c%0d: got v%0b op%h pc%0d exp op%h pc%0d",
                              c, valid_IF_ID, opcode_IF_ID, pc_IF_ID, 4'(c - 2), c - 2);
        end
      end else if (c >= 8) begin
        n_tests++;
        if ({valid_IF_ID, done, instr_IF_ID} !== {1'b0, 1'b1, NOP}) begin
          n_fail++; $display("FAIL program_end c%0d: got v%0b done%0b instr%h exp v0 done1 instr%h",
                              c, valid_IF_ID, done, instr_IF_ID, NOP);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [38:0] e;
    bit found = 0;
    do_reset();
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (valid_IF_ID && pc_IF_ID == 8'd2) found = 1; else tick();
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL stall_wait: pc_IF_ID=2 not seen, got pc %0d exp 2", pc_IF_ID); end
    for (int k = 0; k < 3; k++) begin
      stall = 1; #1;
      e = exp_vec();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL stall_model k%0d: got %h exp %h", k, obs, e); end
      n_tests++;
      if ({imem_en, valid_IF_ID, pc_IF_ID} !== {1'b0, 1'b1, 8'd2}) begin
        n_fail++; $display("FAIL stall_hold k%0d: got en%0b v%0b pc%0d exp en0 v1 pc2", k, imem_en, valid_IF_ID, pc_IF_ID);
      end
      tick();
    end
    stall = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if ({valid_IF_ID, pc_IF_ID} !== {1'b1, 8'(k == 0 ? 2 : 2 + k)}) begin
        n_fail++; $display("FAIL stall_resume k%0d: got v%0b pc%0d exp v1 pc%0d", k, valid_IF_ID, pc_IF_ID, k == 0 ? 2 : 2 + k);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    logic [38:0] e;
    bit found = 0;
    do_reset();
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (imem_en && imem_addr == 8'd4) found = 1; else tick();
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL redirect_wait: PC=4 fetch not seen, got addr %0d exp 4", imem_addr); end
    redirect = 1; redirect_pc = 8'd1;
    tick();
    redirect = 0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      e = exp_vec();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL redirect_model r+%0d: got %h exp %h", k, obs, e); end
      n_tests++;
      if (k < 3 && valid_IF_ID !== 1'b0) begin
        n_fail++; $display("FAIL redirect_bubble r+%0d: got v%0b exp v0", k, valid_IF_ID);
      end else if (k == 3 && {valid_IF_ID, pc_IF_ID, opcode_IF_ID} !== {1'b1, 8'd1, 4'b0001}) begin
        n_fail++; $display("FAIL redirect_target: got v%0b pc%0d op%h exp v1 pc1 op1", valid_IF_ID, pc_IF_ID, opcode_IF_ID);
      end
      tick();
    end
  endtask

  task automatic test_redirect_stall();
    logic [38:0] e;
    logic [7:0] tgt;
    tgt = 8'($urandom_range(0, 5));
    redirect = 1; stall = 1; redirect_pc = tgt;
    tick();
    redirect = 0; stall = 0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      e = exp_vec();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL redir_stall_model r+%0d: got %h exp %h", k, obs, e); end
      if (k == 1) begin
        n_tests++;
        if ({valid_IF_ID, instr_IF_ID} !== {1'b0, NOP}) begin
          n_fail++; $display("FAIL redir_stall_bubble: got v%0b instr%h exp v0 instr%h", valid_IF_ID, instr_IF_ID, NOP);
        end
      end
      if (k == 3) begin
        n_tests++;
        if ({valid_IF_ID, pc_IF_ID} !== {1'b1, tgt}) begin
          n_fail++; $display("FAIL redir_stall_target: got v%0b pc%0d exp v1 pc%0d", valid_IF_ID, pc_IF_ID, tgt);
        end
      end
      tick();
    end
  endtask

  task automatic test_rst_mid();
    bit found = 0;
    int lat = -1;
    do_reset();
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (imem_en && imem_addr == 8'd3) found = 1; else tick();
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL rst_mid_wait: PC=3 not seen, got addr %0d exp 3", imem_addr); end
    rst = 1;
    tick();
    rst = 0; #1;
    n_tests++;
    if (obs !== {NOP, 4'b0101, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL rst_mid_values: got %h exp %h", obs, {NOP, 4'b0101, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0});
    end
    for (int c = 0; c < 6 && lat < 0; c++) begin
      if (c > 0) #1;
      if (valid_IF_ID) lat = c; else tick();
    end
    n_tests++;
    if (lat != 2 || pc_IF_ID !== 8'd0) begin
      n_fail++; $display("FAIL rst_mid_first: got latency %0d pc%0d exp latency 2 pc0", lat, pc_IF_ID);
    end
  endtask

  task automatic test_end_redirect();
    bit found = 0;
    int nvalid = 0;
    logic [7:0] vpc = 8'hxx;
    for (int c = 0; c < 20 && !found; c++) begin
      #1;
      if (done) found = 1; else tick();
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL end_wait: done not seen, got %0b exp 1", done); end
    tick(); tick();
    redirect = 1; redirect_pc = 8'(PROG_LEN - 1);
    tick();
    redirect = 0; #1;
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL end_redirect_drop: got done %0b exp 0", done); end
    for (int c = 0; c < 6; c++) begin
      if (c > 0) #1;
      if (valid_IF_ID) begin nvalid++; vpc = pc_IF_ID; end
      tick();
    end
    #1;
    n_tests++;
    if (nvalid != 1 || vpc !== 8'(PROG_LEN - 1) || done !== 1'b1) begin
      n_fail++; $display("FAIL end_redirect_one: got %0d valid pc%0d done%0b exp 1 valid pc%0d done1",
                          nvalid, vpc, done, PROG_LEN - 1);
    end
  endtask

  task automatic test_random();
    logic [38:0] e;
    int errs = 0;
    int r;
    rst = 1; stall = 0; redirect = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    tick();
    rst = 0;
    for (int c = 0; c < 1500; c++) begin
      r = int'($urandom_range(0, 99));
      rst      = (r < 2);
      redirect = (r >= 2 && r < 12);
      stall    = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0:       redirect_pc = 8'(PROG_LEN - 1);
        1:       redirect_pc = 8'(PROG_LEN);
        2:       redirect_pc = 8'hff;
        3:       redirect_pc = 8'($urandom_range(0, PROG_LEN - 1));
        default: redirect_pc = 8'($urandom);
      endcase
      #1;
      e = exp_vec();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        if (errs < 10) $display("FAIL random c%0d: got %h exp %h", c, obs, e);
        errs++;
      end
      tick();
    end
    rst = 0; redirect = 0; stall = 0;
  endtask

  initial begin
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    load_program();
    test_reset();
    test_program();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_rst_mid();
    test_end_redirect();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
